// File: rtl/signed_accumulator.sv
// signed_accumulator: sequential signed accumulator around a 4-bit signed adder.
// Accepts `len` two's-complement operands over a valid/ready input port,
// keeps a 4-bit running sum plus a sticky overflow flag, and presents the
// result on a valid/ready output port.
//
// Build option: define SIGNED_ACC_SAT_EN for saturating accumulate; otherwise
// the sum wraps around. The sticky overflow flag behaves the same either way.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start, len               begin a run of `len` operands (sampled in IDLE)
//   in_valid, in_data        operand stream input
//   in_ready                 operand accepted this cycle when in_valid=1
//   out_valid, out_data      result handshake and accumulated sum
//   out_ovf                  at least one add in the run overflowed
//   out_ready                consumer accepts the result
//   busy                     block is not IDLE

// Combinational 4-bit signed adder with carry and signed overflow.
module four_bit_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout,
  output logic       overflow
);

  logic [4:0] full_sum;

  assign full_sum = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
  assign sum      = full_sum[3:0];
  assign cout     = full_sum[4];
  // Signed overflow: operands share a sign that the result does not.
  assign overflow = (a[3] == b[3]) && (full_sum[3] != a[3]);

endmodule

module signed_accumulator #(
  parameter int unsigned COUNT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COUNT_W-1:0] len,
  input  logic               in_valid,
  input  logic [3:0]         in_data,
  output logic               in_ready,
  output logic               out_valid,
  output logic [3:0]         out_data,
  output logic               out_ovf,
  input  logic               out_ready,
  output logic               busy
);

  localparam int unsigned DATA_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic                ovf_q, ovf_d;
  logic [COUNT_W-1:0]  cnt_q, cnt_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q, busy_d;

  logic [DATA_W-1:0]   add_sum;
  logic                add_ovf;
  logic                add_cout_unused;
  logic [DATA_W-1:0]   acc_next;
  logic                beat;

  // Accumulator feeds back as operand A; the incoming operand is B.
  four_bit_adder u_adder (
    .a        (acc_q),
    .b        (in_data),
    .cin      (1'b0),
    .sum      (add_sum),
    .cout     (add_cout_unused),
    .overflow (add_ovf)
  );

  // Value loaded into the accumulator on an accepted beat.
  always_comb begin
    acc_next = add_sum;
`ifdef SIGNED_ACC_SAT_EN
    // On overflow both operands share acc's sign, so acc_q[3] picks the rail.
    if (add_ovf) begin
      acc_next = acc_q[DATA_W-1] ? 4'b1000 : 4'b0111;
    end
`endif
  end

  assign beat = in_valid && in_ready_q;

  // Next-state, datapath update and registered-output decode.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = len;
          state_d = (len == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (beat) begin
          acc_d = acc_next;
          ovf_d = ovf_q | add_ovf;
          // Never decrement past zero.
          if (cnt_q != '0) begin
            cnt_d = cnt_q - COUNT_W'(1);
          end
          if (cnt_q <= COUNT_W'(1)) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Handshake outputs are registered copies of the next-state decode.
    in_ready_d  = (state_d == S_RUN);
    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = acc_q;
  assign out_ovf   = ovf_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_signed_accumulator.sv
// Directed testbench for signed_accumulator: hand-computed runs covering plain
// sums, both overflow directions, saturation recovery, zero length with
// back-pressure, input gaps and a mid-run reset.
module tb_signed_accumulator;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] len;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [3:0] out_data;
  logic       out_ovf;
  logic       out_ready;
  logic       busy;

  int total;
  int bad;

  signed_accumulator #(.COUNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock, then settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [3:0] l);
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
    check("busy_after_start", {7'd0, busy}, 8'd1);
  endtask

  task automatic send(input string tag, input logic [3:0] d);
    check(tag, {7'd0, in_ready}, 8'd1);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    in_data  = 4'h0;
  endtask

  task automatic check_result(input string tag, input logic [3:0] d, input logic o);
    check({tag, "_valid"}, {7'd0, out_valid}, 8'd1);
    check({tag, "_data"},  {4'd0, out_data},  {4'd0, d});
    check({tag, "_ovf"},   {7'd0, out_ovf},   {7'd0, o});
    check({tag, "_inrdy"}, {7'd0, in_ready},  8'd0);
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_consumed"}, {6'd0, out_valid, busy}, 8'd0);
  endtask

  initial begin
    logic [3:0] exp_pos;
    logic [3:0] exp_neg;
    logic [3:0] exp_rec;

`ifdef SIGNED_ACC_SAT_EN
    exp_pos = 4'b0111;
    exp_neg = 4'b1000;
    exp_rec = 4'b0110;
`else
    exp_pos = 4'b1001;
    exp_neg = 4'b0111;
    exp_rec = 4'b0111;
`endif

    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    start     = 1'b0;
    len       = 4'd0;
    in_valid  = 1'b0;
    in_data   = 4'h0;
    out_ready = 1'b0;

    // Reset state.
    #2;
    check("reset_outputs", {in_ready, out_valid, out_data, out_ovf, busy}, 8'd0);
    tick();
    rst = 1'b0;
    tick();
    check("idle_outputs", {in_ready, out_valid, busy}, 8'd0);

    // Plain sum 2+3+1 = 6.
    start_run(4'd3);
    send("plain_b0", 4'd2);
    send("plain_b1", 4'd3);
    check("plain_not_early", {7'd0, out_valid}, 8'd0);
    send("plain_b2", 4'd1);
    check_result("plain", 4'b0110, 1'b0);
    consume("plain");

    // Positive overflow 5+4.
    start_run(4'd2);
    send("pos_b0", 4'd5);
    send("pos_b1", 4'd4);
    check_result("pos", exp_pos, 1'b1);
    consume("pos");

    // Negative overflow -8 + -1.
    start_run(4'd2);
    send("neg_b0", 4'b1000);
    send("neg_b1", 4'b1111);
    check_result("neg", exp_neg, 1'b1);
    consume("neg");

    // Recovery after saturation 7, 1, -1.
    start_run(4'd3);
    send("rec_b0", 4'd7);
    send("rec_b1", 4'd1);
    send("rec_b2", 4'b1111);
    check_result("rec", exp_rec, 1'b1);
    consume("rec");

    // Zero length, then back-pressure with ignored start pulses.
    start = 1'b1;
    len   = 4'd0;
    tick();
    start = 1'b0;
    check_result("zero", 4'b0000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      start = (i % 2 == 0);
      len   = 4'd3;
      tick();
      check_result("hold", 4'b0000, 1'b0);
    end
    start = 1'b0;
    consume("zero");

    // Gaps: 3, -2, 4, -1 = 4 with in_valid low every other cycle.
    start_run(4'd4);
    tick();
    send("gap_b0", 4'd3);
    tick();
    send("gap_b1", 4'b1110);
    tick();
    check("gap_mid_valid", {7'd0, out_valid}, 8'd0);
    send("gap_b2", 4'd4);
    tick();
    check("gap_before_last", {7'd0, out_valid}, 8'd0);
    send("gap_b3", 4'b1111);
    check_result("gap", 4'b0100, 1'b0);
    consume("gap");

    // Mid-run reset after two beats aborts the run.
    start_run(4'd5);
    send("rst_b0", 4'd3);
    send("rst_b1", 4'd3);
    #1;
    rst = 1'b1;
    #1;
    check("rst_async", {in_ready, out_valid, out_data, out_ovf, busy}, 8'd0);
    tick();
    rst = 1'b0;
    tick();
    check("rst_idle", {in_ready, out_valid, out_data, out_ovf, busy}, 8'd0);

    // Fresh run starts from zero.
    start_run(4'd1);
    send("fresh_b0", 4'd2);
    check_result("fresh", 4'd2, 1'b0);
    consume("fresh");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/signed_accumulator.md
# signed_accumulator

Sequential signed accumulator that sits directly downstream of the 4-bit signed adder stage and feeds its result back as the next A operand. It accepts a run of `len` 4-bit two's-complement operands over a valid/ready handshake and keeps a running sum in a 4-bit register. It also tracks a sticky overflow flag from the adder's overflow output. At the end of the run it presents the result on a valid/ready output port.

## Interface
- `COUNT_W`, default 4: width of the operand-count input and internal down-counter.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a run; sampled only in IDLE.
- `len`  in  COUNT_W  number of operands in the run; sampled with `start`.
- `in_valid`  in  1  `in_data` is valid.
- `in_data`  in  4  signed operand (two's complement).
- `in_ready`  out  1  block will accept an operand this cycle.
- `out_valid`  out  1  result available.
- `out_data`  out  4  signed accumulated result.
- `out_ovf`  out  1  sticky: at least one add in the run overflowed.
- `out_ready`  in  1  consumer accepts the result.
- `busy`  out  1  state is not IDLE.

## Operation
- Datapath: one `four_bit_adder` instance.
  - A = accumulator register `acc`, B = `in_data`.
  - The block consumes the adder's `sum` and `overflow` outputs; `cout` is unused.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - `in_ready`=0 and `out_valid`=0.
  - When `start`=1: `acc`←0, `ovf`←0, `cnt`←`len`.
  - If `len`=0, go to DONE; otherwise go to RUN.
- RUN:
  - `in_ready`=1.
  - A beat is accepted when `in_valid`=1 and `in_ready`=1. On an accepted beat:
    - `acc`←adder sum (see Configuration).
    - `ovf`←`ovf` | adder overflow.
    - `cnt`←`cnt`−1.
  - When the accepted beat has `cnt`=1, go to DONE.
  - Cycles with `in_valid`=0 change nothing.
- DONE:
  - `out_valid`=1; `out_data`=`acc` and `out_ovf`=`ovf` are held stable.
  - When `out_ready`=1, the result is consumed: go to IDLE. `acc` and `ovf` keep their values until the next `start`.
- `start` is ignored in RUN and DONE.
- `in_data` is ignored outside RUN.
- The counter never wraps: `cnt` only decrements in RUN with `cnt`≥1.
- The maximum run length is 2^COUNT_W − 1 operands.

## Timing
- Reset (async assert, synchronous release at the next edge):
  - state=IDLE; `acc`, `ovf` and `cnt` are 0.
  - Every output is 0: `in_ready`, `out_valid`, `out_data`, `out_ovf`, `busy`.
- Asserting reset mid-RUN or mid-DONE aborts the run; a partial result is never presented.
- `in_ready`, `out_valid` and `busy` are decoded from registered state only; none depends combinationally on `in_valid` or `out_ready`.
- Latency:
  - `start` at edge k gives RUN (`in_ready`=1) from cycle k+1.
  - The last accepted beat at edge m gives `out_valid`=1 from cycle m+1.
  - `len`=0 gives `out_valid`=1 in the cycle after `start`.
- Throughput: one operand per cycle in RUN.
- The result handshake costs one cycle. The next `start` is accepted the cycle after DONE→IDLE, so the minimum gap between runs is two cycles.
- Back-pressure: while in DONE with `out_ready`=0, `out_data` and `out_ovf` are held indefinitely.

## Configuration
- Macro `SIGNED_ACC_SAT_EN`.
- Defined: saturating accumulate.
  - If the adder overflow is 1 on an accepted beat, `acc`←0111 (+7) when both operands were non-negative, and `acc`←1000 (−8) when both were negative.
  - Otherwise `acc`←sum.
- Undefined: wrap-around; `acc`←sum unconditionally.
- The sticky `out_ovf` behaviour is identical in both builds.

## Test plan
- Plain sum: `len`=3, operands 2, 3, 1 → `out_data`=0110 (+6), `out_ovf`=0, `out_valid` one cycle after the third beat.
- Positive overflow: `len`=2, operands 5, 4 → without macro `out_data`=1001 (−7); with macro `out_data`=0111. `out_ovf`=1 in both builds.
- Negative overflow: `len`=2, operands 1000, 1111 → without macro 0111; with macro 1000. `out_ovf`=1.
- Recovery after saturation: `len`=3, operands 7, 1, −1 → without macro 0111 (wraps twice); with macro 0110. `out_ovf`=1.
- Zero length and back-pressure: `len`=0 → `out_valid`=1 the next cycle with `out_data`=0000 and `out_ovf`=0. Then hold `out_ready`=0 for 5 cycles → outputs stable; `start` pulses during this time are ignored.
- Handshake gaps and reset: `len`=4 with `in_valid` low every other cycle → the sum is still correct. Asserting `rst` after 2 beats → all outputs 0 immediately; a fresh run afterwards starts from `acc`=0.
